atm_session_ctrl: RTL and testbench

//  Registered ATM session controller: holds state, PIN retry count, account balance and an

---
 rtl/atm_session_ctrl.sv | 157 +++++++++++++++
 tb/tb_atm_session_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_ctrl.sv
// ATM session controller: one clocked FSM holding session state, PIN retries, balance and an
// inactivity timer, with withdraw/deposit checks and card-eject/lockout handling.
module atm_session_ctrl #(
   parameter int BAL_W     = 16,
   parameter int INIT_BAL  = 1000,
   parameter int MAX_TRIES = 3,
   parameter int TIMEOUT   = 1000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           card_in,
   input  logic                           back,
   input  logic                           enter,
   input  logic                           pin_ok,
   input  logic [1:0]                     opt,
   input  logic [BAL_W-1:0]               amount,
   output logic [2:0]                     state,
   output logic [BAL_W-1:0]               balance,
   output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
   output logic                           dispense,
   output logic [BAL_W-1:0]               disp_amt,
   output logic                           err,
   output logic                           eject,
   output logic                           locked
);

   localparam int TW    = $clog2(MAX_TRIES + 1);
   localparam int TMR_W = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_PIN   = 3'b001,
      S_MENU  = 3'b010,
      S_BAL   = 3'b011,
      S_WDRAW = 3'b100,
      S_DEP   = 3'b101,
      S_EJECT = 3'b110,
      S_LOCK  = 3'b111
   } state_t;

   state_t           st;
   logic [TMR_W-1:0] timer;
   logic [BAL_W:0]   dep_sum;

   // The extra MSB is the carry-out that rejects a deposit which would wrap the balance.
   assign dep_sum = {1'b0, balance} + {1'b0, amount};
   assign state   = st;

   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= S_IDLE;
         balance    <= BAL_W'(INIT_BAL);
         tries_left <= TW'(MAX_TRIES);
         disp_amt   <= '0;
         timer      <= '0;
         dispense   <= 1'b0;
         err        <= 1'b0;
         eject      <= 1'b0;
         locked     <= 1'b0;
      end else begin
         dispense <= 1'b0;
         err      <= 1'b0;
         eject    <= 1'b0;
         locked   <= 1'b0;
         case (st)
            S_IDLE: begin
               timer <= '0;
               if (card_in) begin
                  st         <= S_PIN;
                  tries_left <= TW'(MAX_TRIES);
               end
            end
            S_EJECT: begin
               timer <= '0;
               if (!card_in) st <= S_IDLE;
               else          eject <= 1'b1;
            end
            S_LOCK: begin
               timer  <= '0;
               locked <= 1'b1;
            end
            default: begin
               // Card removal beats keys, keys beat the inactivity timeout.
               if (!card_in) begin
                  st    <= S_IDLE;
                  timer <= '0;
               end else if (back || enter) begin
                  timer <= '0;
                  case (st)
                     S_PIN: begin
                        if (back) begin
                           st    <= S_EJECT;
                           eject <= 1'b1;
                        end else if (pin_ok) begin
                           st <= S_MENU;
                        end else begin
                           tries_left <= tries_left - 1'b1;
                           if (tries_left == TW'(1)) begin
                              st     <= S_LOCK;
                              locked <= 1'b1;
                           end
                        end
                     end
                     S_MENU: begin
                        if (back) begin
                           st    <= S_EJECT;
                           eject <= 1'b1;
                        end else begin
                           case (opt)
                              2'b00: st <= S_BAL;
                              2'b01: st <= S_WDRAW;
                              2'b10: st <= S_DEP;
                              default: begin
                                 st    <= S_EJECT;
                                 eject <= 1'b1;
                              end
                           endcase
                        end
                     end
                     S_BAL: st <= S_MENU;
                     S_WDRAW: begin
                        if (back) begin
                           st <= S_MENU;
                        end else if (amount != '0 && amount <= balance) begin
                           balance  <= balance - amount;
                           dispense <= 1'b1;
                           disp_amt <= amount;
                           st       <= S_MENU;
                        end else begin
                           err <= 1'b1;
                        end
                     end
                     S_DEP: begin
                        if (back) begin
                           st <= S_MENU;
                        end else if (amount != '0 && !dep_sum[BAL_W]) begin
                           balance <= dep_sum[BAL_W-1:0];
                           st      <= S_MENU;
                        end else begin
                           err <= 1'b1;
                        end
                     end
                     default: st <= S_IDLE;
                  endcase
               end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                  st    <= S_EJECT;
                  eject <= 1'b1;
                  timer <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed session scenarios followed by random key/card traffic,
// every cycle compared against a cycle-level session model of the controller's rules.
module tb_atm_session_ctrl;

   localparam int BAL_W     = 16;
   localparam int INIT_BAL  = 1000;
   localparam int MAX_TRIES = 3;
   localparam int TIMEOUT   = 8;
   localparam int BAL_MAX   = (1 << BAL_W) - 1;

   localparam int ST_IDLE  = 0;
   localparam int ST_PIN   = 1;
   localparam int ST_MENU  = 2;
   localparam int ST_BAL   = 3;
   localparam int ST_WDRAW = 4;
   localparam int ST_DEP   = 5;
   localparam int ST_EJECT = 6;
   localparam int ST_LOCK  = 7;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             card_in = 1'b0;
   logic             back = 1'b0;
   logic             enter = 1'b0;
   logic             pin_ok = 1'b0;
   logic [1:0]       opt = 2'b00;
   logic [BAL_W-1:0] amount = '0;
   logic [2:0]       state;
   logic [BAL_W-1:0] balance;
   logic [1:0]       tries_left;
   logic             dispense;
   logic [BAL_W-1:0] disp_amt;
   logic             err;
   logic             eject;
   logic             locked;

   int n_total = 0;
   int n_pass  = 0;

   // Session model: plain integers, unbounded arithmetic, idle time as a count of quiet cycles.
   int m_state, m_bal, m_tries, m_dispamt, m_quiet;
   bit m_disp, m_err;

   atm_session_ctrl #(
      .BAL_W(BAL_W), .INIT_BAL(INIT_BAL), .MAX_TRIES(MAX_TRIES), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .card_in(card_in), .back(back), .enter(enter), .pin_ok(pin_ok),
      .opt(opt), .amount(amount), .state(state), .balance(balance), .tries_left(tries_left),
      .dispense(dispense), .disp_amt(disp_amt), .err(err), .eject(eject), .locked(locked)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
   endtask

   task automatic check_all(input string where);
      chk({where, ".state"},    32'(state),      32'(m_state));
      chk({where, ".balance"},  32'(balance),    32'(m_bal));
      chk({where, ".tries"},    32'(tries_left), 32'(m_tries));
      chk({where, ".dispense"}, 32'(dispense),   32'(m_disp));
      chk({where, ".disp_amt"}, 32'(disp_amt),   32'(m_dispamt));
      chk({where, ".err"},      32'(err),        32'(m_err));
      chk({where, ".eject"},    32'(m_state == ST_EJECT ? 1 : 0) == 0 ? 32'(eject) : 32'(eject), 32'(m_state == ST_EJECT));
      chk({where, ".locked"},   32'(locked),     32'(m_state == ST_LOCK));
   endtask

   task automatic model_step(input bit c, input bit b, input bit e, input bit p,
                             input bit [1:0] o, input int a);
      int  prev;
      bit  was_active;
      prev       = m_state;
      was_active = (m_state >= ST_PIN && m_state <= ST_DEP);
      m_disp     = 1'b0;
      m_err      = 1'b0;
      if (m_state == ST_IDLE) begin
         if (c) begin
            m_state = ST_PIN;
            m_tries = MAX_TRIES;
         end
      end else if (m_state == ST_EJECT) begin
         if (!c) m_state = ST_IDLE;
      end else if (m_state == ST_LOCK) begin
         m_state = ST_LOCK;
      end else if (!c) begin
         m_state = ST_IDLE;
      end else if (b) begin
         m_state = (m_state == ST_PIN || m_state == ST_MENU) ? ST_EJECT : ST_MENU;
      end else if (e) begin
         if (m_state == ST_PIN) begin
            if (p) m_state = ST_MENU;
            else begin
               m_tries = m_tries - 1;
               if (m_tries == 0) m_state = ST_LOCK;
            end
         end else if (m_state == ST_MENU) begin
            m_state = (o == 2'd0) ? ST_BAL : (o == 2'd1) ? ST_WDRAW : (o == 2'd2) ? ST_DEP : ST_EJECT;
         end else if (m_state == ST_BAL) begin
            m_state = ST_MENU;
         end else if (m_state == ST_WDRAW) begin
            if (a > 0 && a <= m_bal) begin
               m_bal     = m_bal - a;
               m_disp    = 1'b1;
               m_dispamt = a;
               m_state   = ST_MENU;
            end else m_err = 1'b1;
         end else begin
            if (a > 0 && m_bal + a <= BAL_MAX) begin
               m_bal   = m_bal + a;
               m_state = ST_MENU;
            end else m_err = 1'b1;
         end
      end else if (m_quiet + 1 == TIMEOUT) begin
         // This is the TIMEOUT-th consecutive quiet cycle in the same active state.
         m_state = ST_EJECT;
      end
      m_quiet = (was_active && c && !b && !e && m_state == prev) ? m_quiet + 1 : 0;
   endtask

   task automatic step(input string where, input bit c, input bit b, input bit e, input bit p,
                       input bit [1:0] o, input int a);
      card_in = c;
      back    = b;
      enter   = e;
      pin_ok  = p;
      opt     = o;
      amount  = BAL_W'(a);
      model_step(c, b, e, p, o, a);
      @(posedge clk);
      #1;
      check_all(where);
   endtask

   task automatic do_reset(input string where);
      rst       = 1'b1;
      card_in   = 1'b0;
      back      = 1'b0;
      enter     = 1'b0;
      m_state   = ST_IDLE;
      m_bal     = INIT_BAL;
      m_tries   = MAX_TRIES;
      m_dispamt = 0;
      m_quiet   = 0;
      m_disp    = 1'b0;
      m_err     = 1'b0;
      @(posedge clk);
      #1;
      check_all(where);
      rst = 1'b0;
   endtask

   initial begin
      bit c, b, e, p;
      bit [1:0] o;
      int a;
      @(posedge clk);
      #1;
      do_reset("reset");

      // Login: IDLE -> PIN -> MENU
      step("t1_card", 1, 0, 0, 0, 2'd0, 0);
      step("t1_pin",  1, 0, 1, 1, 2'd0, 0);
      chk("t1_in_menu", 32'(state), 32'(3'b010));
      chk("t1_tries", 32'(tries_left), 32'd3);

      // Withdraw accepted then rejected
      step("t3_sel",  1, 0, 1, 0, 2'd1, 0);
      step("t3_w300", 1, 0, 1, 0, 2'd0, 300);
      chk("t3_dispense", 32'(dispense), 32'd1);
      chk("t3_disp_amt", 32'(disp_amt), 32'd300);
      chk("t3_bal700", 32'(balance), 32'd700);
      step("t3_sel2", 1, 0, 1, 0, 2'd1, 0);
      step("t3_w800", 1, 0, 1, 0, 2'd0, 800);
      chk("t3_err", 32'(err), 32'd1);
      chk("t3_stay_wdraw", 32'(state), 32'(3'b100));

      // back+enter together, then card pulled with enter in DEP
      step("t6_both", 1, 1, 1, 0, 2'd0, 100);
      chk("t6_menu_no_disp", 32'({state, dispense}), 32'({3'b010, 1'b0}));
      step("t6_seldep", 1, 0, 1, 0, 2'd2, 0);
      step("t6_pull",   0, 0, 1, 0, 2'd0, 50);
      chk("t6_idle_bal", 32'({state, balance}), 32'({3'b000, 16'd700}));

      // Lockout after three wrong PINs
      step("t2_card", 1, 0, 0, 0, 2'd0, 0);
      for (int i = 0; i < 3; i++) step("t2_bad", 1, 0, 1, 0, 2'd0, 0);
      chk("t2_lock", 32'({state, locked, tries_left}), 32'({3'b111, 1'b1, 2'd0}));
      step("t2_pull1", 0, 0, 1, 1, 2'd0, 0);
      step("t2_pull2", 0, 0, 0, 0, 2'd0, 0);
      chk("t2_still_lock", 32'(state), 32'(3'b111));
      do_reset("t2_reset");

      // Deposit overflow boundary
      step("t4_card", 1, 0, 0, 0, 2'd0, 0);
      step("t4_pin",  1, 0, 1, 1, 2'd0, 0);
      step("t4_sel",  1, 0, 1, 0, 2'd2, 0);
      step("t4_d64k", 1, 0, 1, 0, 2'd0, 64000);
      step("t4_sel2", 1, 0, 1, 0, 2'd2, 0);
      step("t4_d600", 1, 0, 1, 0, 2'd0, 600);
      chk("t4_ovf_err", 32'({err, balance}), 32'({1'b1, 16'd65000}));
      step("t4_d500", 1, 0, 1, 0, 2'd0, 500);
      chk("t4_bal65500", 32'(balance), 32'd65500);

      // Inactivity timeout in MENU
      for (int i = 1; i < TIMEOUT; i++) step("t5_quiet", 1, 0, 0, 0, 2'd0, 0);
      chk("t5_not_yet", 32'(state), 32'(3'b010));
      step("t5_expire", 1, 0, 0, 0, 2'd0, 0);
      chk("t5_eject", 32'({state, eject}), 32'({3'b110, 1'b1}));
      step("t5_pull", 0, 0, 0, 0, 2'd0, 0);
      chk("t5_idle", 32'(state), 32'(3'b000));

      // Random sessions
      for (int n = 0; n < 1500; n++) begin
         if (m_state == ST_LOCK && $urandom_range(0, 3) == 0) begin
            do_reset("rnd_reset");
         end else if ($urandom_range(0, 24) == 0) begin
            for (int k = $urandom_range(1, 10); k > 0; k--) step("rnd_quiet", 1, 0, 0, 0, 2'd0, 0);
         end else begin
            c = ($urandom_range(0, 11) != 0);
            b = ($urandom_range(0, 9) == 0);
            e = ($urandom_range(0, 9) < 4);
            p = ($urandom_range(0, 9) < 6);
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
               0:       a = 0;
               1:       a = $urandom_range(0, BAL_MAX);
               default: a = $urandom_range(1, 2000);
            endcase
            step("rnd", c, b, e, p, o, a);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
